irq_request_ctrl: RTL and testbench

IRQ_REQUEST_CTRL -- requirements
Module: irq_request_ctrl

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_edge_detect.sv | 25 ++
 rtl/irq_request_ctrl.sv | 124 ++++++++++++
 tb/tb_irq_request_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, FSM state encoding and helpers for the interrupt request controller.
package irq_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2
  } irq_state_e;

  // One-hot mask for the source index returned by the downstream encoder.
  function automatic logic [NUM_SRC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the interrupt lines; rises are discarded while enb is low.
module irq_edge_detect
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic [NUM_SRC-1:0] rise_c
);

  logic [NUM_SRC-1:0] irq_prev;

  // Previous level tracks every cycle so re-enabling does not fabricate rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_in;
    end
  end

  assign rise_c = enb ? (irq_in & ~irq_prev) : '0;

endmodule

// File: rtl/irq_request_ctrl.sv
// Captures interrupt rising edges, presents a frozen request snapshot and retires it on ack.
// Optional ack timeout is enabled by defining IRQ_ACK_TIMEOUT_EN.
module irq_request_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] req_vec,
  output logic               req_valid,
  input  logic [IDX_W-1:0]   sel_idx,
  input  logic               ack,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic               timeout_err
);

  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_cfg
    $error("irq_request_ctrl: ACK_TIMEOUT must be within 1..255");
  end

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] rise_c;
  logic [NUM_SRC-1:0] snap_d;
  logic [NUM_SRC-1:0] clr_c;
  logic [NUM_SRC-1:0] unmasked_c;
  logic               timeout_hit_c;

  irq_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .enb    (enb),
    .irq_in (irq_in),
    .rise_c (rise_c)
  );

  assign unmasked_c = pending & ~mask;

  // Next state, next snapshot and the pending bit retired by an ack.
  always_comb begin
    state_d = state_q;
    snap_d  = req_vec;
    clr_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (enb && (unmasked_c != '0)) begin
          state_d = ST_WAIT_ACK;
          snap_d  = unmasked_c;
        end
      end
      ST_WAIT_ACK: begin
        if (!enb) begin
          state_d = ST_GAP;
          snap_d  = '0;
        end else if (ack) begin
          state_d = ST_GAP;
          snap_d  = '0;
          clr_c   = req_vec & idx_onehot(sel_idx);
        end else if (timeout_hit_c) begin
          state_d = ST_GAP;
          snap_d  = '0;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        snap_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        snap_d  = '0;
      end
    endcase
  end

  // A fresh rise on a bit being acked in the same cycle keeps it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_vec   <= '0;
      req_valid <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
    end else begin
      state_q   <= state_d;
      req_vec   <= snap_d;
      req_valid <= (state_d == ST_WAIT_ACK);
      busy      <= (state_d != ST_IDLE);
      pending   <= (pending & ~clr_c) | rise_c;
    end
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  logic [CNT_W-1:0] ack_cnt_q;

  // Counter holds the number of completed unacked WAIT_ACK cycles.
  assign timeout_hit_c = (CNT_W'(ack_cnt_q + CNT_W'(1)) == CNT_W'(ACK_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt_q <= '0;
    end else if ((state_q == ST_WAIT_ACK) && (state_d == ST_WAIT_ACK)) begin
      ack_cnt_q <= CNT_W'(ack_cnt_q + CNT_W'(1));
    end else begin
      ack_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if ((state_q == ST_WAIT_ACK) && enb && !ack && timeout_hit_c) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit_c = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Randomized and directed bench for irq_request_ctrl against a transaction-level reference model.
module tb_irq_request_ctrl;

  localparam int ACK_TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] irq_in = 4'b0;
  logic [3:0] mask = 4'b0;
  logic [1:0] sel_idx = 2'b0;
  logic [3:0] req_vec;
  logic       req_valid;
  logic [3:0] pending;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1 = presenting, 2 = gap.
  logic [3:0] m_pend, m_prev, m_snap;
  int         m_phase, m_waited;
  logic       m_terr;

  irq_request_ctrl #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .irq_in      (irq_in),
    .mask        (mask),
    .req_vec     (req_vec),
    .req_valid   (req_valid),
    .sel_idx     (sel_idx),
    .ack         (ack),
    .pending     (pending),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 4'b0; m_prev = 4'b0; m_snap = 4'b0;
    m_phase = 0; m_waited = 0; m_terr = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] rise, clear;
    rise   = enb ? (irq_in & ~m_prev) : 4'b0;
    m_prev = irq_in;
    clear  = 4'b0;
    if (m_phase == 0) begin
      if (enb && ((m_pend & ~mask) != 4'b0)) begin
        m_snap = m_pend & ~mask;
        m_phase = 1;
        m_waited = 0;
      end
    end else if (m_phase == 1) begin
      m_waited++;
      if (!enb) begin
        m_phase = 2;
      end else if (ack) begin
        if (m_snap[sel_idx]) clear[sel_idx] = 1'b1;
        m_phase = 2;
      end else begin
`ifdef IRQ_ACK_TIMEOUT_EN
        if (m_waited == ACK_TO) begin
          m_terr = 1'b1;
          m_phase = 2;
        end
`endif
      end
      if (m_phase == 2) m_snap = 4'b0;
    end else begin
      m_phase = 0;
    end
    m_pend = (m_pend & ~clear) | rise;
  endtask

  task automatic compare_all();
    check("req_vec",     32'(req_vec),     32'((m_phase == 1) ? m_snap : 4'b0));
    check("req_valid",   32'(req_valid),   32'(m_phase == 1));
    check("pending",     32'(pending),     32'(m_pend));
    check("busy",        32'(busy),        32'(m_phase != 0));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // One clock: apply inputs after the falling edge, advance model at the rising edge, check at the next falling edge.
  task automatic cycle(input logic e, input logic [3:0] i, input logic [3:0] m,
                       input logic [1:0] s, input logic a);
    enb = e; irq_in = i; mask = m; sel_idx = s; ack = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_reset(input logic [3:0] hold_irq);
    #2;
    rst = 1'b1;
    irq_in = hold_irq;
    ack = 1'b0;
    #1;
    check("rst_req_vec",   32'(req_vec),     32'(0));
    check("rst_req_valid", 32'(req_valid),   32'(0));
    check("rst_pending",   32'(pending),     32'(0));
    check("rst_busy",      32'(busy),        32'(0));
    check("rst_terr",      32'(timeout_err), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ack_pct;
    logic [3:0] r_irq, r_mask;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Single source: latency, presentation and ack clear.
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0100, 4'b0000, 2'd0, 0);
    check("lat_pending", 32'(pending), 32'(4'b0100));
    check("lat_valid_early", 32'(req_valid), 32'(0));
    cycle(1, 4'b0100, 4'b0000, 2'd0, 0);
    check("lat_valid", 32'(req_valid), 32'(1));
    check("lat_vec", 32'(req_vec), 32'(4'b0100));
    cycle(1, 4'b0100, 4'b0000, 2'd2, 1);
    check("ack_pending", 32'(pending), 32'(0));
    check("gap_busy", 32'(busy), 32'(1));
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);
    check("idle_busy", 32'(busy), 32'(0));

    // Two simultaneous rises, ack the higher one.
    cycle(1, 4'b1001, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);
    check("dual_vec", 32'(req_vec), 32'(4'b1001));
    cycle(1, 4'b0000, 4'b0000, 2'd3, 1);
    check("dual_pending", 32'(pending), 32'(4'b0001));
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);
    check("dual_next_vec", 32'(req_vec), 32'(4'b0001));
    cycle(1, 4'b0000, 4'b0000, 2'd0, 1);
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);

    // Masked source stays pending until unmasked; later mask change does not disturb the snapshot.
    cycle(1, 4'b0100, 4'b0100, 2'd0, 0);
    cycle(1, 4'b0100, 4'b0100, 2'd0, 0);
    check("mask_pending", 32'(pending), 32'(4'b0100));
    check("mask_valid", 32'(req_valid), 32'(0));
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);
    check("unmask_vec", 32'(req_vec), 32'(4'b0100));
    cycle(1, 4'b0000, 4'b1111, 2'd0, 0);
    check("snap_hold", 32'(req_vec), 32'(4'b0100));
    cycle(1, 4'b0000, 4'b0000, 2'd2, 1);
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);

    // Ack and a fresh rise on the same bit: the bit survives and is re-presented.
    cycle(1, 4'b0010, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0010, 4'b0000, 2'd1, 1);
    check("setwins_pending", 32'(pending), 32'(4'b0010));
    cycle(1, 4'b0010, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0010, 4'b0000, 2'd0, 0);
    check("setwins_vec", 32'(req_vec), 32'(4'b0010));
    cycle(1, 4'b0000, 4'b0000, 2'd1, 1);
    cycle(1, 4'b0000, 4'b0000, 2'd0, 0);

    // No ack for a long stretch.
    cycle(1, 4'b1000, 4'b0000, 2'd0, 0);
    repeat (ACK_TO + 1) cycle(1, 4'b1000, 4'b0000, 2'd0, 0);
`ifdef IRQ_ACK_TIMEOUT_EN
    check("to_err", 32'(timeout_err), 32'(1));
`else
    check("to_valid", 32'(req_valid), 32'(1));
    check("to_err", 32'(timeout_err), 32'(0));
`endif
    check("to_pending", 32'(pending), 32'(4'b1000));
    repeat (4) cycle(1, 4'b0000, 4'b0000, 2'd3, 1);

    // Reset while presenting, line held high across release.
    cycle(1, 4'b0001, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0001, 4'b0000, 2'd0, 0);
    pulse_reset(4'b0010);
    cycle(1, 4'b0010, 4'b0000, 2'd0, 0);
    cycle(1, 4'b0010, 4'b0000, 2'd0, 0);
    check("rel_vec", 32'(req_vec), 32'(4'b0010));
    check("rel_pending", 32'(pending), 32'(4'b0010));
    cycle(1, 4'b0010, 4'b0000, 2'd1, 1);
    check("rel_once", 32'(pending), 32'(4'b0000));
    cycle(1, 4'b0010, 4'b0000, 2'd0, 0);

    // Random traffic with phases of frequent, rare and absent acks.
    ack_pct = 40;
    r_irq = 4'b0;
    r_mask = 4'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 0;
          1: ack_pct = 5;
          default: ack_pct = 40;
        endcase
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 99) < 20) r_irq[b] = ~r_irq[b];
      if ($urandom_range(0, 99) < 5) r_mask = 4'($urandom);
      if ($urandom_range(0, 999) < 3) begin
        pulse_reset(r_irq);
      end else begin
        cycle($urandom_range(0, 99) < 92, r_irq, r_mask, 2'($urandom),
              $urandom_range(0, 99) < ack_pct);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
